// File: rtl/rr_arb4_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package rr_arb4_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: searches ptr+1, ptr+2, ptr+3, ptr (mod 4)
// and returns the first requesting index.
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  sel_t               i_ptr,
  output sel_t               o_idx,
  output logic               o_found
);

  sel_t w_cand;

  // Scan from lowest priority to highest so the last hit written wins.
  always_comb begin
    o_idx   = i_ptr;
    o_found = 1'b0;
    w_cand  = i_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = i_ptr + sel_t'(k);
      if (i_req[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter driving the mux4x4 select and a valid/ready beat handshake.
// Optional burst lock selected with macro RR_ARB4_LOCK_EN (holds the grant until LAST or
// HOLD_MAX beats); without it the grant rotates after every beat.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_last,
  input  logic               i_ready,
  output sel_t               o_s,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_valid,
  output logic               o_beat
);

  arb_state_t         r_state, w_state_nxt;
  sel_t               r_s, w_s_nxt;
  sel_t               r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;

  logic w_valid, w_beat, w_done, w_release;
  sel_t w_pick_ptr, w_win;
  logic w_found;

`ifdef RR_ARB4_LOCK_EN
  localparam int unsigned CntW = $clog2(HOLD_MAX + 1);
  logic [CntW-1:0] r_cnt, w_cnt_nxt;

  // Burst ends on LAST or on the beat that brings the count up to HOLD_MAX.
  assign w_done = i_last[r_s] || (r_cnt == CntW'(HOLD_MAX - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (^i_last) ^ (HOLD_MAX == 0);
  assign w_done       = 1'b1;
`endif

  assign w_valid   = (r_state == GRANT) && i_req[r_s];
  assign w_beat    = w_valid && i_ready;
  // Withdrawal releases without a beat; otherwise release needs a finishing beat.
  assign w_release = (r_state == GRANT) && (!i_req[r_s] || (w_beat && w_done));

  // On release the search starts after the current holder, which becomes the new PTR.
  // A withdrawn holder has REQ low, so it is naturally excluded from the re-arbitration.
  assign w_pick_ptr = (r_state == GRANT) ? r_s : r_ptr;

  rr_pick4 u_pick (
    .i_req   (i_req),
    .i_ptr   (w_pick_ptr),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  // Next-state and grant/select update.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
`ifdef RR_ARB4_LOCK_EN
    w_cnt_nxt   = r_cnt;
`endif
    unique case (r_state)
      IDLE: begin
        w_gnt_nxt = '0;
        if (w_found) begin
          w_state_nxt = GRANT;
          w_s_nxt     = w_win;
          w_gnt_nxt   = 4'b0001 << w_win;
`ifdef RR_ARB4_LOCK_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr_nxt = r_s;
          if (w_found) begin
            w_s_nxt   = w_win;
            w_gnt_nxt = 4'b0001 << w_win;
`ifdef RR_ARB4_LOCK_EN
            w_cnt_nxt = '0;
`endif
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end
`ifdef RR_ARB4_LOCK_EN
        else if (w_beat) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Select, grant and pointer registers; PTR resets to 3 so requester 0 wins first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s   <= '0;
      r_gnt <= '0;
      r_ptr <= 2'd3;
    end else begin
      r_s   <= w_s_nxt;
      r_gnt <= w_gnt_nxt;
      r_ptr <= w_ptr_nxt;
    end
  end

`ifdef RR_ARB4_LOCK_EN
  // Beat counter for the current burst.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`endif

  assign o_s     = r_s;
  assign o_gnt   = r_gnt;
  assign o_valid = w_valid;
  assign o_beat  = w_beat;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: vector tables fed through a scoreboard queue,
// plus hand-written reset checks. Lock-mode vectors are used when RR_ARB4_LOCK_EN is set.
module tb_rr_arb4;
  import rr_arb4_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, last;
  logic       ready;
  sel_t       s;
  logic [3:0] gnt;
  logic       valid, beat;

  always #5 clk = ~clk;

  rr_arb4 #(.HOLD_MAX(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_last  (last),
    .i_ready (ready),
    .o_s     (s),
    .o_gnt   (gnt),
    .o_valid (valid),
    .o_beat  (beat)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       ready;
    logic [1:0] s;
    logic [3:0] gnt;
    logic       valid;
    logic       beat;
  } vec_t;

  vec_t sb[$];
  vec_t pre[$];
  vec_t post[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] l, input logic rd,
                              input logic [1:0] es, input logic [3:0] eg, input logic ev,
                              input logic eb);
    vec_t v;
    v.req = r; v.last = l; v.ready = rd;
    v.s = es; v.gnt = eg; v.valid = ev; v.beat = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_now(input int idx, input logic [1:0] es, input logic [3:0] eg,
                           input logic ev, input logic eb);
    chk("S", idx, {2'b00, s}, {2'b00, es});
    chk("GNT", idx, gnt, eg);
    chk("VALID", idx, {3'b000, valid}, {3'b000, ev});
    chk("BEAT", idx, {3'b000, beat}, {3'b000, eb});
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    req   = v.req;
    last  = v.last;
    ready = v.ready;
    sb.push_back(v);
    @(negedge clk);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard step %0d: got empty queue expected one entry", idx);
    end else begin
      e = sb.pop_front();
      check_now(idx, e.s, e.gnt, e.valid, e.beat);
    end
  endtask

  initial begin
`ifdef RR_ARB4_LOCK_EN
    // Burst ends on LAST[0] at beat 3, then requester 1 runs HOLD_MAX=4 beats (one stall).
    pre.push_back(mk(4'b0011, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
    pre.push_back(mk(4'b0011, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
    pre.push_back(mk(4'b0011, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
    pre.push_back(mk(4'b0011, 4'b0000, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1));
    pre.push_back(mk(4'b0011, 4'b0000, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1));
    pre.push_back(mk(4'b0011, 4'b0000, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0));
    pre.push_back(mk(4'b0011, 4'b0000, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1));
    pre.push_back(mk(4'b0011, 4'b0000, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1));
    pre.push_back(mk(4'b0011, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
    // Requester 0 withdraws, requester 3 takes over; reset hits during its 2nd beat.
    pre.push_back(mk(4'b1000, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0));
    pre.push_back(mk(4'b1000, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1));
    pre.push_back(mk(4'b1000, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1));
    // After reset: a fresh count gives requester 3 exactly 4 beats before rotating to 0.
    post.push_back(mk(4'b1001, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1));
    post.push_back(mk(4'b1001, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1));
    post.push_back(mk(4'b1001, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1));
    post.push_back(mk(4'b1001, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1));
    post.push_back(mk(4'b1001, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
`else
    // Fairness: all requesting, S walks 0,1,2,3,0 with a beat every cycle.
    pre.push_back(mk(4'b1111, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
    pre.push_back(mk(4'b1111, 4'b0000, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1));
    pre.push_back(mk(4'b1111, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1));
    pre.push_back(mk(4'b1111, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1));
    pre.push_back(mk(4'b1111, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
    // Requester 1 withdraws at once; requester 2 granted and stalled 5 cycles.
    pre.push_back(mk(4'b0100, 4'b0000, 1'b0, 2'd1, 4'b0010, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++)
      pre.push_back(mk(4'b0100, 4'b0000, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0));
    pre.push_back(mk(4'b0100, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1));
    // Requester 2 regranted alone, then drops; requester 1 granted, then withdraws to 3.
    pre.push_back(mk(4'b0010, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0));
    pre.push_back(mk(4'b0010, 4'b0000, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0));
    pre.push_back(mk(4'b1000, 4'b0000, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b0));
    pre.push_back(mk(4'b1000, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1));
    // No requests: back to idle, S holds at 3.
    pre.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b0));
    pre.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0));
    pre.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0));
    pre.push_back(mk(4'b0001, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0));
    // Requester 0 alone repeats; requester 2 arriving mid-grant waits for release.
    pre.push_back(mk(4'b0001, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
    pre.push_back(mk(4'b0101, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
    pre.push_back(mk(4'b0101, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1));
    pre.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0));
    pre.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0));
    // Requester 3 granted from idle; reset hits during its 2nd beat.
    pre.push_back(mk(4'b1000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    pre.push_back(mk(4'b1000, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1));
    pre.push_back(mk(4'b1000, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1));
    post.push_back(mk(4'b1000, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1));
    post.push_back(mk(4'b0001, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b0));
    post.push_back(mk(4'b0001, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
`endif

    // Reset held with everyone requesting: nothing granted.
    rst_n = 1'b0;
    req   = 4'b1111;
    last  = 4'b0000;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check_now(-1, 2'd0, 4'b0000, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < pre.size(); i++) step(pre[i], i);

    // Asynchronous reset mid-beat: outputs clear without waiting for a clock edge.
    #2 rst_n = 1'b0;
    #1 check_now(-2, 2'd0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < post.size(); i++) step(post[i], 100 + i);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
